// File: rtl/audio_pkg.sv
// Shared audio definitions: tone codes, channel indices, arbiter states and
// the per-channel code/duration tables used by sound_event_arbiter.
package audio_pkg;

  localparam int unsigned SND_NONE   = 0;
  localparam int unsigned SND_EDGE   = 3;
  localparam int unsigned SND_CRASH  = 4;
  localparam int unsigned SND_FINISH = 6;
  localparam int unsigned SND_BONUS  = 7;

  // Channel index doubles as priority: lower index wins.
  typedef enum logic [2:0] {
    CH_CRASH  = 3'd0,
    CH_EDGE   = 3'd1,
    CH_FINISH = 3'd2,
    CH_BONUS  = 3'd3,
    CH_SPARE4 = 3'd4,
    CH_SPARE5 = 3'd5,
    CH_SPARE6 = 3'd6,
    CH_SPARE7 = 3'd7
  } channel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Tone code per channel; spare channels are silent.
  function automatic int unsigned tone_code(input int unsigned ch);
    if (ch == 32'(CH_CRASH))  return SND_CRASH;
    if (ch == 32'(CH_EDGE))   return SND_EDGE;
    if (ch == 32'(CH_FINISH)) return SND_FINISH;
    if (ch == 32'(CH_BONUS))  return SND_BONUS;
    return SND_NONE;
  endfunction

  // Duration in frames per channel; spare channels last one frame.
  function automatic int unsigned tone_duration(input int unsigned ch);
    if (ch == 32'(CH_CRASH))  return 3;
    if (ch == 32'(CH_EDGE))   return 3;
    if (ch == 32'(CH_FINISH)) return 4;
    if (ch == 32'(CH_BONUS))  return 5;
    return 1;
  endfunction

  // Fit a duration into a w-bit timer: 0 plays as 1, oversize saturates.
  function automatic int unsigned clamp_duration(input int unsigned d,
                                                 input int unsigned w);
    int unsigned lim;
    lim = (32'd1 << w) - 32'd1;
    if (d == 0)  return 1;
    if (d > lim) return lim;
    return d;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Lowest-index-first priority encoder.
//   req   : request vector
//   idx   : index of the lowest set bit (0 when none set)
//   valid : high when any request bit is set
module priority_encoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the last hit is the lowest index.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (req[i-1]) begin
        idx   = IDX_W'(i - 1);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sound_event_arbiter.sv
// Sound-effect arbiter: latches one-cycle event pulses into pending bits,
// plays the highest-priority channel's tone for its frame duration, with
// optional preemption, retrigger and a silent gap between sounds.
//   clk, reset   : clock, asynchronous active-high reset
//   frame_start  : one-cycle pulse per video frame (duration time base)
//   event_req    : per-channel request pulses, channel 0 highest priority
//   mute         : level; silences outputs, arbitration continues
//   enable_sound : high while a channel is audible
//   sound        : tone code, zero when silent
//   active_id    : playing channel, 0 when not playing
//   busy         : playing, in gap, or requests pending
module sound_event_arbiter #(
  parameter int unsigned NUM_EVENTS = 8,
  parameter int unsigned CODE_W     = 4,
  parameter int unsigned TIMER_W    = 6,
  parameter int unsigned GAP_FRAMES = 1,
  parameter bit          PREEMPT    = 1'b1,
  parameter bit          RETRIGGER  = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic [NUM_EVENTS-1:0]         event_req,
  input  logic                          mute,
  output logic                          enable_sound,
  output logic [CODE_W-1:0]             sound,
  output logic [$clog2(NUM_EVENTS)-1:0] active_id,
  output logic                          busy
);

  import audio_pkg::*;

  localparam int unsigned        ID_W     = $clog2(NUM_EVENTS);
  localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_FRAMES);

  state_e                  state_q, state_d;
  logic [NUM_EVENTS-1:0]   pending_q, pending_d;
  logic [TIMER_W-1:0]      timer_q, timer_d;
  logic [ID_W-1:0]         active_id_q, active_id_d;
  logic                    enable_q, enable_d;
  logic [CODE_W-1:0]       sound_q, sound_d;
  logic                    busy_q, busy_d;

  logic [ID_W-1:0]         win;
  logic                    win_valid;
  logic                    load;
  logic [NUM_EVENTS-1:0]   start_mask;

  logic [CODE_W-1:0]       code_tbl [NUM_EVENTS];
  logic [TIMER_W-1:0]      dur_tbl  [NUM_EVENTS];

  for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_tbl
    assign code_tbl[g] = CODE_W'(tone_code(g));
    assign dur_tbl[g]  = TIMER_W'(clamp_duration(tone_duration(g), TIMER_W));
  end

  priority_encoder #(
    .WIDTH (NUM_EVENTS),
    .IDX_W (ID_W)
  ) u_win (
    .req   (pending_q),
    .idx   (win),
    .valid (win_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      timer_q     <= '0;
      active_id_q <= '0;
      enable_q    <= 1'b0;
      sound_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      timer_q     <= timer_d;
      active_id_q <= active_id_d;
      enable_q    <= enable_d;
      sound_q     <= sound_d;
      busy_q      <= busy_d;
    end
  end

  // Next state. A load (new channel starting) overrides any decrement or
  // retrigger computed earlier in the same cycle.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    active_id_d = active_id_q;
    load        = 1'b0;
    start_mask  = '0;

    unique case (state_q)
      IDLE: begin
        if (win_valid) load = 1'b1;
      end
      PLAY: begin
        if (PREEMPT && win_valid && (win < active_id_q)) begin
          load = 1'b1;
        end else if (RETRIGGER && event_req[active_id_q]) begin
          // Absorb the retrigger pulse so it does not replay the channel later.
          timer_d                 = dur_tbl[active_id_q];
          start_mask[active_id_q] = 1'b1;
        end else if (frame_start) begin
          if (timer_q <= TIMER_W'(1)) begin
            if (GAP_FRAMES != 0) begin
              state_d     = GAP;
              timer_d     = GAP_LOAD;
              active_id_d = '0;
            end else if (win_valid) begin
              load = 1'b1;
            end else begin
              state_d     = IDLE;
              timer_d     = '0;
              active_id_d = '0;
            end
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
      end
      GAP: begin
        if (frame_start) begin
          if (timer_q <= TIMER_W'(1)) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
      end
      default: begin
        state_d     = IDLE;
        timer_d     = '0;
        active_id_d = '0;
      end
    endcase

    if (load) begin
      state_d         = PLAY;
      active_id_d     = win;
      timer_d         = dur_tbl[win];
      start_mask[win] = 1'b1;
    end

    pending_d = (pending_q | event_req) & ~start_mask;
  end

  // Outputs are registered from next-state values so they track the state
  // change on the same edge.
  always_comb begin
    enable_d = (state_d == PLAY) && !mute;
    sound_d  = enable_d ? code_tbl[active_id_d] : '0;
    busy_d   = (state_d != IDLE) || (pending_d != '0);
  end

  assign enable_sound = enable_q;
  assign sound        = sound_q;
  assign active_id    = active_id_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sound_event_arbiter.sv
// Directed bench for sound_event_arbiter with default parameters.
module tb_sound_event_arbiter;

  logic       clk;
  logic       reset;
  logic       frame_start;
  logic [7:0] event_req;
  logic       mute;
  logic       enable_sound;
  logic [3:0] sound;
  logic [2:0] active_id;
  logic       busy;

  int unsigned n_checks;
  int unsigned n_errors;

  sound_event_arbiter #(
    .NUM_EVENTS (8),
    .CODE_W     (4),
    .TIMER_W    (6),
    .GAP_FRAMES (1),
    .PREEMPT    (1'b1),
    .RETRIGGER  (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (frame_start),
    .event_req    (event_req),
    .mute         (mute),
    .enable_sound (enable_sound),
    .sound        (sound),
    .active_id    (active_id),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int unsigned got,
                       input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, pass the edge, return 1ns after it.
  task automatic cyc(input logic fs, input logic [7:0] req);
    frame_start = fs;
    event_req   = req;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    event_req   = '0;
  endtask

  // n video frames, each a frame_start pulse followed by two quiet cycles.
  task automatic frames(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      cyc(1'b1, 8'h00);
      cyc(1'b0, 8'h00);
      cyc(1'b0, 8'h00);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    frame_start = 1'b0;
    event_req   = '0;
    mute        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sound",  sound,        0);
    check("rst_enable", enable_sound, 0);
    check("rst_busy",   busy,         0);
    check("rst_id",     active_id,    0);
    reset = 1'b0;
    cyc(1'b0, 8'h00);

    // Single request on bonus: 2-cycle latency, 5 frames, 1-frame gap.
    cyc(1'b0, 8'h08);
    check("t1_lat1_sound", sound, 0);
    check("t1_lat1_busy",  busy,  1);
    cyc(1'b0, 8'h00);
    check("t1_sound",  sound,        7);
    check("t1_enable", enable_sound, 1);
    check("t1_id",     active_id,    3);
    frames(4);
    check("t1_f4_sound", sound, 7);
    frames(1);
    check("t1_f5_sound",  sound,        0);
    check("t1_f5_enable", enable_sound, 0);
    check("t1_f5_busy",   busy,         1);
    frames(1);
    check("t1_gap_busy", busy, 0);
    frames(4);
    check("t1_f10_sound", sound, 0);

    // Preemption of bonus by crash; bonus is dropped.
    cyc(1'b0, 8'h08);
    cyc(1'b0, 8'h00);
    frames(2);
    cyc(1'b0, 8'h01);
    check("t2_pre_sound", sound, 7);
    cyc(1'b0, 8'h00);
    check("t2_preempt_sound", sound,     4);
    check("t2_preempt_id",    active_id, 0);
    frames(2);
    check("t2_f2_sound", sound, 4);
    frames(1);
    check("t2_f3_sound", sound, 0);
    frames(1);
    check("t2_end_busy", busy, 0);
    cyc(1'b0, 8'h00);
    check("t2_no_replay", sound, 0);

    // Queueing: finish then bonus after crash, gaps between.
    cyc(1'b0, 8'h01);
    cyc(1'b0, 8'h00);
    check("t3_crash", sound, 4);
    cyc(1'b0, 8'h0C);
    cyc(1'b0, 8'h00);
    check("t3_no_preempt", sound, 4);
    frames(3);
    check("t3_gap1_sound", sound, 0);
    check("t3_gap1_busy",  busy,  1);
    frames(1);
    check("t3_finish",    sound,     6);
    check("t3_finish_id", active_id, 2);
    frames(4);
    check("t3_gap2_sound", sound, 0);
    frames(1);
    check("t3_bonus",    sound,     7);
    check("t3_bonus_id", active_id, 3);
    frames(5);
    frames(1);
    check("t3_end_busy", busy, 0);

    // Retrigger coinciding with the final frame of edge.
    cyc(1'b0, 8'h02);
    cyc(1'b0, 8'h00);
    check("t4_edge", sound, 3);
    frames(2);
    cyc(1'b1, 8'h02);
    check("t4_retrig_sound", sound, 3);
    frames(2);
    check("t4_f2_sound", sound, 3);
    frames(1);
    check("t4_f3_sound", sound, 0);
    frames(1);
    check("t4_end_busy", busy, 0);

    // Mute during crash; timing continues underneath.
    cyc(1'b0, 8'h01);
    cyc(1'b0, 8'h00);
    check("t5_crash", sound, 4);
    mute = 1'b1;
    cyc(1'b0, 8'h00);
    check("t5_mute_sound",  sound,        0);
    check("t5_mute_enable", enable_sound, 0);
    check("t5_mute_busy",   busy,         1);
    frames(2);
    mute = 1'b0;
    cyc(1'b0, 8'h00);
    check("t5_unmute_sound",  sound,        4);
    check("t5_unmute_enable", enable_sound, 1);
    frames(1);
    check("t5_expire_sound", sound, 0);
    frames(1);
    check("t5_end_busy", busy, 0);

    // Asynchronous reset mid-sound with pending requests.
    cyc(1'b0, 8'h08);
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h06);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_sound",  sound,        0);
    check("t6_async_enable", enable_sound, 0);
    check("t6_async_busy",   busy,         0);
    check("t6_async_id",     active_id,    0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    check("t6_post_sound", sound, 0);
    check("t6_post_busy",  busy,  0);
    cyc(1'b0, 8'h02);
    cyc(1'b0, 8'h00);
    check("t6_new_sound", sound, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sound_event_arbiter.md
# sound_event_arbiter

Parametrised sound-effect arbiter for the audio path. It captures one-cycle game and collision event pulses into per-channel pending bits and picks the highest-priority channel. It plays that channel's tone code for a per-channel number of video frames, with optional preemption, retrigger and inter-sound silence. It sits between the game-state/collision logic and the tone generator, and replaces the earlier fixed four-event sound mux.

## Interface
- NUM_EVENTS, 8: number of event channels; channel 0 has the highest priority.
- CODE_W, 4: width of the tone code driven to the tone generator.
- TIMER_W, 6: width of the frame countdown; durations are limited to 2^TIMER_W-1.
- GAP_FRAMES, 1: silent frames inserted between consecutive sounds; 0 disables the gap.
- PREEMPT, 1: if 1, a higher-priority request aborts the sound that is playing.
- RETRIGGER, 1: if 1, a request on the playing channel reloads its timer.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse per video frame; this is the duration time base.
- event_req  in  NUM_EVENTS  one-cycle request pulses, one bit per channel.
- mute  in  1  level; forces sound and enable_sound low, while arbitration keeps running.
- enable_sound  out  1  high while a channel is audible.
- sound  out  CODE_W  tone code; all zeros when silent.
- active_id  out  $clog2(NUM_EVENTS)  index of the playing channel; 0 when idle.
- busy  out  1  high in PLAY or GAP, or whenever any pending bit is set.

## Operation
- Reset values: state IDLE, pending all 0, timer 0, enable_sound 0, sound 0, active_id 0, busy 0. Reset mid-sound silences the output immediately (asynchronous) and discards all pending requests.
- Pending: pending <= (pending | event_req) & ~start_mask. A request that arrives in the same cycle its own channel starts is absorbed; it does not leave a stale pending bit. Multiple pulses on a channel before service merge into one.
- Selection: win = lowest index set in pending.
- IDLE: if pending != 0 → PLAY. On that edge load active_id=win and timer=DURATION[win], and clear pending[win].
- PLAY, on each frame_start: timer decrements. When timer==1, exit at the same edge: to GAP with timer=GAP_FRAMES if GAP_FRAMES>0, otherwise directly to IDLE-equivalent selection. Back-to-back sounds therefore have no dead cycle when GAP_FRAMES=0.
- PLAY preemption (PREEMPT=1): if win < active_id, switch to win at the next edge. Load its duration and clear its pending bit. The aborted channel is dropped, not re-queued, and no gap is inserted.
- PLAY retrigger (RETRIGGER=1): event_req[active_id] reloads timer to DURATION[active_id]. Preemption wins if both occur in the same cycle.
- GAP: sound 0 and enable_sound 0. Timer decrements on frame_start; at timer==1 with frame_start → IDLE. New requests keep accumulating in pending.
- Duration 0 in the table is treated as 1.
- Outputs are registered. While in PLAY and mute is 0: enable_sound=1 and sound=CODE[active_id]. Otherwise enable_sound=0 and sound=0.
- A frame_start and a selection change in the same cycle: the load takes precedence over the decrement.

## Timing
- Latency: event_req high at edge k. From IDLE, enable_sound and sound are valid after edge k+1, i.e. 2 cycles.
- Preemption: request at edge k gives the new code after edge k+1.
- A sound lasts exactly DURATION frame_start pulses, counted from the first frame_start after the load edge. Its wall-clock length is therefore between DURATION-1 and DURATION frames.
- mute affects outputs one cycle after it changes.
- The block has no handshake with the tone generator; sound is a level.

## Structure
- Shared package audio_pkg:
  - tone code constants: SND_NONE=0, SND_EDGE=3, SND_CRASH=4, SND_FINISH=6, SND_BONUS=7;
  - the channel index enum (CH_CRASH=0, CH_EDGE=1, CH_FINISH=2, CH_BONUS=3, remaining channels spare);
  - the CODE and DURATION table functions indexed by channel (crash 3, edge 3, finish 4, bonus 5 frames; spare channels code 0, duration 1);
  - the state enum {IDLE, PLAY, GAP}.
- One sub-module: priority_encoder. It is parametrised on width and outputs the lowest set index plus a valid flag. It is reused for win.

## Test plan
- Single request: event_req[3] pulse, 10 frames of frame_start → sound=7 and enable_sound=1 two cycles later. Silence after the 5th frame_start, then a 1-frame gap; busy drops after the gap.
- Preemption: play bonus (ch3), pulse ch0 mid-sound → sound=4 one cycle later, lasting 3 frames. Channel 3 is not replayed.
- Queueing: ch0 playing, pulse ch2 and ch3 together → after crash plus gap, finish (6) plays, then gap, then bonus (7). Pending is empty at the end.
- Retrigger plus frame coincidence: ch1 playing with timer=1, event_req[1] and frame_start in the same cycle → timer reloads to 3 and the sound continues for 3 more frames.
- Mute: assert mute during crash → sound=0 and enable_sound=0 next cycle, while state and timer still expire on schedule. Deassert mute mid-sound → tone resumes.
- Reset mid-sound with pending bits set → outputs 0 asynchronously. After release there is no sound until a new event_req arrives.
